// File: rtl/dma_desc_sequencer_if.sv
// Descriptor (host) and byte-transfer (DMA controller) channels of dma_desc_sequencer.
// master = environment side (host + DMA controller), slave = the sequencer.
interface dma_desc_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
);
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_src;
  logic [ADDR_W-1:0] desc_dst;
  logic [LEN_W-1:0]  desc_len;
  logic              dma_start;
  logic [ADDR_W-1:0] dma_src;
  logic [ADDR_W-1:0] dma_dst;
  logic              dma_done;

  modport master (
    output desc_valid, desc_src, desc_dst, desc_len, dma_done,
    input  desc_ready, dma_start, dma_src, dma_dst
  );

  modport slave (
    input  desc_valid, desc_src, desc_dst, desc_len, dma_done,
    output desc_ready, dma_start, dma_src, dma_dst
  );
endinterface

// File: rtl/dma_desc_sequencer.sv
// Queues multi-byte copy descriptors and replays each as single-byte DMA start/done transfers.
// Optional watchdog on the WAIT state: define DMA_TIMEOUT_EN.
module dma_desc_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int LEN_W       = 4,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dma_desc_sequencer_if.slave    bus,
  output logic                   desc_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err,
  input  logic                   err_clr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
  } desc_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t            state, state_n;
  desc_t             mem [DEPTH];
  desc_t             head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] cur_src, cur_dst;
  logic [LEN_W-1:0]  remaining;
  logic              push, pop, step, timeout, wait_expired;

  assign head           = mem[rd_ptr];
  assign bus.desc_ready = (fifo_count != CNT_W'(DEPTH));
  assign push           = bus.desc_valid && bus.desc_ready;
  assign busy           = (state != IDLE) || (fifo_count != '0);
  // The controller reads these combinationally during its READ/WRITE states.
  assign bus.dma_src    = cur_src;
  assign bus.dma_dst    = cur_dst;

  // NOTE: descriptor storage is deliberately not reset; rd/wr pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.desc_src, bus.desc_dst, bus.desc_len};
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_n       = state;
    pop           = 1'b0;
    step          = 1'b0;
    timeout       = 1'b0;
    bus.dma_start = 1'b0;
    desc_done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_n = (head.len == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        bus.dma_start = 1'b1;
        state_n       = WAIT;
      end
      WAIT: begin
        if (bus.dma_done) begin
          step    = 1'b1;
          state_n = (remaining == LEN_W'(1)) ? FINISH : ISSUE;
        end else if (wait_expired) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      FINISH: begin
        desc_done = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        cur_src   <= head.src;
        cur_dst   <= head.dst;
        remaining <= head.len;
      end else if (step) begin
        cur_src   <= cur_src + ADDR_W'(1);
        cur_dst   <= cur_dst + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end else if (timeout) begin
        remaining <= '0;
      end
    end
  end

`ifdef DMA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] wait_cnt;

  // Counter is held at 0 outside WAIT, so it starts from 0 on every WAIT entry.
  assign wait_expired = (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + TO_W'(1) : '0;
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign wait_expired   = 1'b0;
  assign err            = 1'b0;
`endif
endmodule
